// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stager: op encodings, FSM states, default width.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_CMP = 2'd2,
        OP_NEG = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_EXEC   = 3'd2,
        ST_CAPT   = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

    // Every op except ADD runs the ALU in subtract mode (NEG is 0 - x).
    function automatic logic op_subtracts(input op_e op);
        return op != OP_ADD;
    endfunction

endpackage

// File: rtl/alu_result_buf.sv
// Holds one captured ALU result and offers it downstream with a valid/ready handshake.
module alu_result_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             capture_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             carry_i,
    input  logic             zero_i,
    input  logic             res_ready_i,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_carry_o,
    output logic             res_zero_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            carry_d = carry_i;
            zero_d  = zero_i;
        end else if (valid_q && res_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the result payload is reset too, because it is visible on ports and must read 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            valid_q <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign res_valid_o = valid_q;
    assign res_data_o  = data_q;
    assign res_carry_o = carry_q;
    assign res_zero_o  = zero_q;

endmodule

// File: rtl/alu_operand_stager.sv
// Two-beat operand feeder for the 8-bit ALU with a single-entry result buffer downstream.
module alu_operand_stager
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             flush,
    output logic [WIDTH-1:0] areg,
    output logic [WIDTH-1:0] breg,
    output logic             doSubtract,
    output logic             assertE,
    input  logic [WIDTH-1:0] aluOut,
    input  logic             flagCarry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic             do_sub_q, do_sub_d;
    logic             capture;
    op_e              in_op_e;

    assign in_op_e = op_e'(in_op);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        do_sub_d = do_sub_q;
        in_ready = 1'b0;
        assertE  = 1'b0;
        capture  = 1'b0;

        unique case (state_q)
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d     = in_op_e;
                    do_sub_d = op_subtracts(in_op_e);
                    // NEG is a single beat: the ALU computes 0 - x.
                    if (in_op_e == OP_NEG) begin
                        areg_d  = '0;
                        breg_d  = in_data;
                        state_d = ST_EXEC;
                    end else begin
                        areg_d  = in_data;
                        state_d = ST_LOAD_B;
                    end
                end
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    breg_d  = in_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                assertE = 1'b1;
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                capture = 1'b1;
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) state_d = ST_LOAD_A;
            end
            default: state_d = ST_LOAD_A;
        endcase

        // Flush overrides any beat accepted this cycle and any capture about to happen.
        if (flush) begin
            state_d  = ST_LOAD_A;
            op_d     = op_q;
            areg_d   = areg_q;
            breg_d   = breg_q;
            do_sub_d = do_sub_q;
            capture  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_LOAD_A;
            op_q     <= OP_ADD;
            areg_q   <= '0;
            breg_q   <= '0;
            do_sub_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            do_sub_q <= do_sub_d;
        end
    end

    assign areg       = areg_q;
    assign breg       = breg_q;
    assign doSubtract = do_sub_q;

    // CMP keeps A as its result while still reporting the ALU's carry and zero.
    alu_result_buf #(.WIDTH(WIDTH)) u_result_buf (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .capture_i  (capture),
        .data_i     ((op_q == OP_CMP) ? areg_q : aluOut),
        .carry_i    (flagCarry),
        .zero_i     (aluOut == '0),
        .res_ready_i(res_ready),
        .res_valid_o(res_valid),
        .res_data_o (res_data),
        .res_carry_o(res_carry),
        .res_zero_o (res_zero)
    );

endmodule

// File: tb/tb_alu_operand_stager.sv
// Bench for alu_operand_stager with a behavioural 8-bit ALU and a queue-based result scoreboard.
module tb_alu_operand_stager;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [1:0]   in_op = 2'd0;
    logic         flush = 1'b0;
    logic [W-1:0] areg, breg;
    logic         doSubtract, assertE;
    logic [W-1:0] aluOut;
    logic         flagCarry;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W-1:0] res_data;
    logic         res_carry, res_zero;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_exec = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    alu_operand_stager #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .flush(flush),
        .areg(areg), .breg(breg), .doSubtract(doSubtract), .assertE(assertE),
        .aluOut(aluOut), .flagCarry(flagCarry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero)
    );

    // Reference ALU: combinational result, carry flag updated on the EXEC edge.
    logic [W:0] alu_sum;
    assign alu_sum = {1'b0, areg} + {1'b0, breg};
    assign aluOut  = doSubtract ? (areg - breg) : alu_sum[W-1:0];

    always @(posedge clk or negedge reset) begin
        if (!reset)       flagCarry <= 1'b0;
        else if (assertE) flagCarry <= doSubtract ? (areg >= breg) : alu_sum[W];
    end

    always @(negedge clk) if (assertE) n_exec++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected result.
    always @(negedge clk) begin
        if (reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_result: got data 0x%0h with no result expected", res_data);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("result", {res_data, res_carry, res_zero}, {e.data, e.carry, e.zero});
            end
        end
    end

    task automatic beat(input logic [W-1:0] d, input logic [1:0] op);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op == 2'd3) begin
            beat(b, op);
        end else begin
            beat(a, op);
            beat(b, op);
        end
    endtask

    task automatic expect_res(input logic [W-1:0] d, input logic c, input logic z);
        res_t e;
        e.data  = d;
        e.carry = c;
        e.zero  = z;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("res_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] d, input logic c, input logic z);
        expect_res(d, c, z);
        issue(op, a, b);
        drain();
    endtask

    initial begin
        int exec0;

        #12;
        check("reset_outputs",
              {areg, breg, doSubtract, assertE, res_valid, res_data, res_carry, res_zero}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // ADD with explicit latency: B accepted at edge t, res_valid after edge t+2.
        expect_res(8'h08, 1'b0, 1'b0);
        issue(2'd0, 8'h05, 8'h03);
        @(posedge clk);
        #1 check("latency_t1_res_valid", res_valid, 32'd0);
        @(posedge clk);
        #1 check("latency_t2_res_valid", res_valid, 32'd1);
        drain();

        run(2'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        run(2'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
        run(2'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1);
        run(2'd2, 8'h07, 8'h02, 8'h07, 1'b1, 1'b0);
        run(2'd3, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);

        // Backpressure: result held for 5 cycles, no new beats accepted, one EXEC pulse.
        res_ready = 1'b0;
        exec0 = n_exec;
        expect_res(8'h32, 1'b0, 1'b0);
        issue(2'd0, 8'h10, 8'h22);
        wait_valid();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {res_valid, res_data, res_carry, res_zero}, {1'b1, 8'h32, 1'b0, 1'b0});
            check("bp_in_ready", in_ready, 32'd0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        drain();
        check("bp_exec_pulses", n_exec - exec0, 32'd1);

        // Flush in LOAD_B together with a beat: flush wins, beat dropped.
        beat(8'h40, 2'd0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h99;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        check("flush_loadb_state", {in_ready, res_valid, assertE}, {1'b1, 1'b0, 1'b0});
        run(2'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // Flush while a result is held: result discarded, never handed downstream.
        res_ready = 1'b0;
        issue(2'd0, 8'h11, 8'h22);
        wait_valid();
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        res_ready = 1'b1;
        check("flush_result_state", {in_ready, res_valid}, {1'b1, 1'b0});
        run(2'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // Asynchronous reset while in EXEC.
        issue(2'd1, 8'h44, 8'h33);
        #1 check("pre_reset_exec", {assertE, doSubtract}, {1'b1, 1'b1});
        #1 reset = 1'b0;
        #1 check("async_reset_outputs",
                 {areg, breg, doSubtract, assertE, res_valid, res_data, res_carry, res_zero}, 32'd0);
        repeat (2) @(posedge clk);
        #1 check("reset_held_no_result", res_valid, 32'd0);
        reset = 1'b1;
        run(2'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
